// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner ids and the
// fixed read mask used for instruction fetches.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_LS = 1'b1;

    localparam logic [7:0] MEM_RD_MASK = 8'hFF;

    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive LS wins taken while IF was waiting; at_limit
// tells the arbiter to hand the next grant to IF.
import mem_port_arbiter_pkg::*;

module arb_starve_cnt (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    clr,
    input  logic [STARVE_CNT_W-1:0] limit,
    output logic                    at_limit,
    output logic [STARVE_CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < limit)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with LS priority and a starvation guard for IF.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rsp_data,
    input  logic          ls_req_valid,
    output logic          ls_req_ready,
    input  logic [AW-1:0] ls_req_addr,
    input  logic          ls_req_wen,
    input  logic [DW-1:0] ls_req_wdata,
    input  logic [7:0]    ls_req_wmask,
    output logic          ls_rsp_valid,
    output logic [DW-1:0] ls_rsp_data,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic          mem_req_wen,
    output logic [DW-1:0] mem_req_wdata,
    output logic [7:0]    mem_req_wmask,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          busy,
    output logic          owner,
    output logic [1:0]    dbg_state
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state;
    logic                    arb_en;
    logic                    at_limit;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    idle_ok;
    logic                    ls_win;
    logic                    ls_grant;
    logic                    if_grant;
    logic                    rsp_fire;

    // Grants stay off until the first edge after reset release.
    assign idle_ok  = (state == ARB_IDLE) && arb_en;
    assign ls_win   = ls_req_valid && (!if_req_valid || !at_limit);
    assign ls_grant = idle_ok && ls_win;
    assign if_grant = idle_ok && if_req_valid && !ls_win;

    assign ls_req_ready = ls_grant;
    assign if_req_ready = if_grant;

    arb_starve_cnt u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (ls_grant && if_req_valid),
        .clr      (if_grant),
        .limit    (LIMIT),
        .at_limit (at_limit),
        .cnt      (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_IDLE;
            arb_en        <= 1'b0;
            owner         <= ARB_OWN_IF;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            arb_en <= 1'b1;
            case (state)
                ARB_IDLE: begin
                    if (ls_grant) begin
                        mem_req_addr  <= ls_req_addr;
                        mem_req_wen   <= ls_req_wen;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_wmask <= ls_req_wmask;
                        owner         <= ARB_OWN_LS;
                        state         <= ARB_REQ;
                    end else if (if_grant) begin
                        mem_req_addr  <= if_req_addr;
                        mem_req_wen   <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= MEM_RD_MASK;
                        owner         <= ARB_OWN_IF;
                        state         <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) state <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem_rsp_valid) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Responses only count while waiting; earlier ones are dropped.
    assign rsp_fire      = (state == ARB_WAIT) && mem_rsp_valid;
    assign if_rsp_valid  = rsp_fire && (owner == ARB_OWN_IF);
    assign ls_rsp_valid  = rsp_fire && (owner == ARB_OWN_LS);
    assign if_rsp_data   = mem_rsp_data;
    assign ls_rsp_data   = mem_rsp_data;

    assign mem_req_valid = (state == ARB_REQ);
    assign busy          = (state != ARB_IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, away from the rising edge.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic          clk;
  logic          rst_n;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_req_addr;
  logic          ls_req_wen;
  logic [DW-1:0] ls_req_wdata;
  logic [7:0]    ls_req_wmask;
  logic          ls_rsp_valid;
  logic [DW-1:0] ls_rsp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [DW-1:0] mem_req_wdata;
  logic [7:0]    mem_req_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          busy;
  logic          owner;
  logic [1:0]    dbg_state;

  int n_cmp;
  int n_fail;
  logic [0:0] exp_q[$];

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rsp_data   (ls_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy),
    .owner         (owner),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // IF read with immediate acceptance and a response in the first WAIT cycle.
  task automatic if_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    step();
    if_req_valid = 1'b1; if_req_addr = addr; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL if_txn_ready got=%b exp=1", if_req_ready); end
    step();
    if_req_valid = 1'b0;
    #1;
    n_cmp++; if (dbg_state !== S_REQ || mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL if_txn_req state=%0d mem_req_valid=%b exp=1/1", dbg_state, mem_req_valid); end
    n_cmp++; if (mem_req_addr !== addr || mem_req_wen !== 1'b0 || mem_req_wmask !== 8'hFF) begin n_fail++; $display("FAIL if_txn_fields addr=%h wen=%b mask=%h exp=%h/0/ff", mem_req_addr, mem_req_wen, mem_req_wmask, addr); end
    n_cmp++; if (if_rsp_valid !== 1'b0 || owner !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL if_txn_c1 rsp=%b owner=%b busy=%b exp=0/0/1", if_rsp_valid, owner, busy); end
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== data) begin n_fail++; $display("FAIL if_txn_rsp valid=%b data=%h exp=1/%h", if_rsp_valid, if_rsp_data, data); end
    n_cmp++; if (ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_txn_ls_quiet got=%b exp=0", ls_rsp_valid); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0 || dbg_state !== S_IDLE || owner !== 1'b0 || ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL if_txn_done rsp=%b state=%0d owner=%b ls=%b exp=0/0/0/0", if_rsp_valid, dbg_state, owner, ls_rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step(); step();
    #1;
    n_cmp++; if (dbg_state !== S_IDLE || busy !== 1'b0 || owner !== 1'b0) begin n_fail++; $display("FAIL reset_state state=%0d busy=%b owner=%b exp=0/0/0", dbg_state, busy, owner); end
    n_cmp++; if (mem_req_valid !== 1'b0 || mem_req_addr !== '0 || mem_req_wen !== 1'b0 || mem_req_wdata !== '0 || mem_req_wmask !== 8'h00) begin n_fail++; $display("FAIL reset_mem_req valid=%b addr=%h wmask=%h exp=0/0/0", mem_req_valid, mem_req_addr, mem_req_wmask); end
    n_cmp++; if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready if=%b ls=%b exp=0/0", if_req_ready, ls_req_ready); end
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=0", if_req_ready); end
    if_req_valid = 1'b0;
  endtask

  task automatic test_if_read();
    if_txn(64'h8000_0000, 64'h0010_0073);
  endtask

  task automatic test_ls_store();
    step();
    mem_req_ready = 1'b0;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
    ls_req_wdata = 64'h1122_3344_5566_7788; ls_req_wmask = 8'h0F;
    #1;
    n_cmp++; if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready ls=%b if=%b exp=1/0", ls_req_ready, if_req_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      ls_req_valid = 1'b0; ls_req_addr = 64'hdead; ls_req_wen = 1'b0; ls_req_wdata = '1; ls_req_wmask = 8'hA5;
      mem_req_ready = (i == 3);
      #1;
      n_cmp++;
      if (dbg_state !== S_REQ || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000 || mem_req_wen !== 1'b1 ||
          mem_req_wdata !== 64'h1122_3344_5566_7788 || mem_req_wmask !== 8'h0F || owner !== 1'b1) begin
        n_fail++;
        $display("FAIL st_hold%0d state=%0d v=%b addr=%h wen=%b wdata=%h mask=%h owner=%b exp=1/1/80001000/1/1122334455667788/0f/1",
                 i, dbg_state, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, owner);
      end
    end
    step();
    #1;
    n_cmp++; if (dbg_state !== S_WAIT || mem_req_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL st_wait state=%0d v=%b rsp=%b exp=2/0/0", dbg_state, mem_req_valid, ls_rsp_valid); end
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0;
    #1;
    n_cmp++; if (ls_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL st_rsp ls=%b if=%b exp=1/0", ls_rsp_valid, if_rsp_valid); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (ls_rsp_valid !== 1'b0 || dbg_state !== S_IDLE || owner !== 1'b1) begin n_fail++; $display("FAIL st_done rsp=%b state=%0d owner=%b exp=0/0/1", ls_rsp_valid, dbg_state, owner); end
  endtask

  task automatic test_contention();
    logic [0:0] exp_own;
    logic [0:0] got_own;
    exp_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ls_req_wen = 1'b0; ls_req_addr = 64'h8000_2000; ls_req_wmask = 8'hFF;
    if_req_addr = 64'h8000_0100;
    mem_req_ready = 1'b1; mem_rsp_data = 64'h55;
    for (int t = 0; t < 10; t++) begin
      step();
      if_req_valid = 1'b1; ls_req_valid = 1'b1; mem_rsp_valid = 1'b0;
      #1;
      exp_own = exp_q.pop_front();
      got_own = ls_req_ready;
      n_cmp++;
      if ((if_req_ready ^ ls_req_ready) !== 1'b1 || got_own !== exp_own) begin
        n_fail++;
        $display("FAIL cont_grant%0d if_ready=%b ls_ready=%b exp_ls=%b", t, if_req_ready, ls_req_ready, exp_own);
      end
      step();
      step();
      mem_rsp_valid = 1'b1;
      #1;
      n_cmp++;
      if (ls_rsp_valid !== exp_own || if_rsp_valid !== ~exp_own || owner !== exp_own) begin
        n_fail++;
        $display("FAIL cont_rsp%0d ls=%b if=%b owner=%b exp_ls=%b", t, ls_rsp_valid, if_rsp_valid, owner, exp_own);
      end
    end
    step();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  task automatic test_spurious();
    step();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL spur_idle if=%b ls=%b state=%0d exp=0/0/0", if_rsp_valid, ls_rsp_valid, dbg_state); end
    step();
    mem_rsp_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    step();
    if_req_valid = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0 || dbg_state !== S_REQ) begin n_fail++; $display("FAIL spur_req if=%b ls=%b state=%0d exp=0/0/1", if_rsp_valid, ls_rsp_valid, dbg_state); end
    step();
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0 || dbg_state !== S_REQ) begin n_fail++; $display("FAIL spur_req_acc rsp=%b state=%0d exp=0/1", if_rsp_valid, dbg_state); end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b0 || dbg_state !== S_WAIT) begin n_fail++; $display("FAIL spur_wait rsp=%b state=%0d exp=0/2", if_rsp_valid, dbg_state); end
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h1234;
    #1;
    n_cmp++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 64'h1234) begin n_fail++; $display("FAIL spur_real rsp=%b data=%h exp=1/1234", if_rsp_valid, if_rsp_data); end
    step();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    step();
    mem_req_ready = 1'b1;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3000; ls_req_wen = 1'b0; ls_req_wmask = 8'hFF;
    step();
    ls_req_valid = 1'b0;
    step();
    #1;
    n_cmp++; if (dbg_state !== S_WAIT || owner !== 1'b1) begin n_fail++; $display("FAIL rw_pre state=%0d owner=%b exp=2/1", dbg_state, owner); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || dbg_state !== S_IDLE || mem_req_valid !== 1'b0 || owner !== 1'b0) begin n_fail++; $display("FAIL rw_async busy=%b state=%0d v=%b owner=%b exp=0/0/0/0", busy, dbg_state, mem_req_valid, owner); end
    step();
    rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hFEED;
    #1;
    n_cmp++; if (ls_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rw_late ls=%b if=%b state=%0d exp=0/0/0", ls_rsp_valid, if_rsp_valid, dbg_state); end
    step();
    mem_rsp_valid = 1'b0;
    if_txn(64'h8000_0400, 64'h0000_0013);
  endtask

  task automatic test_back_to_back();
    int gap;
    int pulses;
    gap = 0; pulses = 0;
    step();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h77;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0500;
    #1;
    n_cmp++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first got=%b exp=1", if_req_ready); end
    for (int c = 1; c <= 20; c++) begin
      step();
      #1;
      if (if_rsp_valid === 1'b1) pulses++;
      if (if_req_ready === 1'b1) begin
        gap = c;
        break;
      end
    end
    n_cmp++; if (gap !== 3) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=3", gap); end
    n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    step();
    if_req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (dbg_state === S_IDLE) break;
      step();
    end
    #1;
    n_cmp++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL b2b_drain state=%0d exp=0", dbg_state); end
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_if_read();
    test_ls_store();
    test_contention();
    test_spurious();
    test_reset_in_wait();
    test_back_to_back();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Multi-cycle arbiter that shares the single memory port between instruction fetch (IF) and load/store (LS). It sits between the core's fetch and memory-access stages and the DPI-backed memory model, replacing the separate instruction and data memory instances. It serialises one transaction at a time through an IDLE/REQ/WAIT state machine. Arbitration gives LS fixed priority, with a starvation guard for IF.

## Interface
Parameters:
- AW, 64, address width
- DW, 64, data width
- STARVE_LIMIT, 4, consecutive LS wins over a pending IF before IF is forced; range 1..15

Ports (reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  AW  fetch address
- if_rsp_valid  out  1  IF response, one-cycle pulse
- if_rsp_data  out  DW  fetch data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_addr  in  AW  load/store address
- ls_req_wen  in  1  1 = store
- ls_req_wdata  in  DW  store data
- ls_req_wmask  in  8  byte mask; store bytes or read mask
- ls_rsp_valid  out  1  LS response, one-cycle pulse, also for stores
- ls_rsp_data  out  DW  load data; don't-care for stores
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  AW/1/DW/8  latched request fields
- mem_rsp_valid  in  1  downstream response
- mem_rsp_data  in  DW  downstream read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = LS; owner of the current or last transaction

## Operation
- States:
  - IDLE: no transaction in flight.
  - REQ: mem_req_valid is high; waiting for mem_req_ready.
  - WAIT: waiting for mem_rsp_valid.
- IDLE arbitration:
  - LS valid and (IF not valid or starve_cnt < STARVE_LIMIT): grant LS.
  - Otherwise, if IF valid: grant IF.
  - Only the winner's req_ready is high. Both ready signals are low outside IDLE.
- Grant handshake (valid & ready):
  - Latch addr, wen, wdata and wmask into the mem_req_* registers. For IF, wen=0 and wmask=8'hFF.
  - Set owner and go to REQ.
- REQ: hold mem_req_valid and all fields stable. On mem_req_ready go to WAIT.
- WAIT: on mem_rsp_valid, pulse the owner's rsp_valid and pass mem_rsp_data through combinationally, then go to IDLE.
- mem_rsp_valid in IDLE or REQ is ignored.
- Non-owner rsp_valid is always 0. Both rsp_data outputs carry mem_rsp_data.
- starve_cnt, 4 bits:
  - Increments, saturating at STARVE_LIMIT, when LS is granted while if_req_valid=1.
  - Clears when IF is granted.
  - Holds otherwise.
- Requesters hold valid and fields stable until ready; the arbiter does not check this.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; starve_cnt 0; owner 0; mem_req_* registers 0.
  - All valid and ready outputs 0, except that the IDLE grant logic resumes on the first edge after release.
- Minimum transaction, with mem_req_ready high and the response one cycle later:
  - C0: IDLE handshake.
  - C1: REQ, mem_req_valid=1, ready=1.
  - C2: WAIT, mem_rsp_valid=1, rsp_valid pulse.
  - C3: IDLE, next grant possible.
- Peak throughput: one transaction per 3 cycles. No pipelining, one outstanding transaction.
- Reset asserted in REQ or WAIT:
  - Transaction is abandoned; no rsp_valid is produced.
  - A late mem_rsp_valid after reset is ignored (state IDLE).
- Simultaneous IF and LS valid with starve_cnt == STARVE_LIMIT: IF wins and starve_cnt clears.
- mem_req_ready already high on entry to REQ: exactly one cycle in REQ.
- mem_rsp_valid and mem_req_ready both high in REQ: the response is ignored, and the downstream must not respond before acceptance.

## Structure
- Add to the shared defines header, next to the existing select encodings:
  - State encodings: ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2.
  - Owner encodings: ARB_OWN_IF=1'b0, ARB_OWN_LS=1'b1.
  - IF read mask 8'hFF, reusing the existing read-mask define.
- One sub-module, arb_starve_cnt: saturating counter with inputs inc, clr and limit, and output at_limit.
- The state register, request latches and response routing stay in mem_port_arbiter.

## Test plan
- IF-only read:
  - Stimulus: if_req_addr=0x80000000; memory returns 0x00100073 with mem_req_ready immediate.
  - Required: if_rsp_valid for one cycle exactly 2 cycles after the handshake, if_rsp_data=0x00100073, owner=0, ls_rsp_valid never high.
- LS store:
  - Stimulus: addr 0x80001000, wdata 0x1122334455667788, wmask 8'h0F, wen=1.
  - Required: mem_req_* match and stay stable across 3 cycles of mem_req_ready=0; one ls_rsp_valid pulse.
- Contention:
  - Stimulus: IF and LS held valid continuously, STARVE_LIMIT=4.
  - Required: grant order LS,LS,LS,LS,IF,LS…; starve_cnt returns to 0 after the IF grant.
- Spurious response:
  - Stimulus: mem_rsp_valid pulsed in IDLE and in REQ.
  - Required: no rsp_valid on either side, state unaffected.
- Reset in WAIT:
  - Stimulus: rst_n low for 1 cycle during an LS load, then mem_rsp_valid.
  - Required: busy=0 immediately, no ls_rsp_valid, next IF request served normally.
- Back-to-back IF requests:
  - Stimulus: two IF requests with 0-cycle memory latency.
  - Required: second if_req_ready no earlier than 3 cycles after the first.
